fft_reorder: RTL and testbench
==============================

# fft_reorder

Output reorder buffer downstream of the radix-2 butterfly array of the 16-point Q16.16 FFT. Accepts one complex result per cycle in bit-reversed index order, as the final butterfly stage emits them, and streams the frame out in natural order. Two ping-pong banks let frame k+1 be written while frame k is read, sustaining one sample per cycle with valid/ready backpressure on both sides.

## Interface
- N, 16, FFT length in complex samples; power of two, 8..64
- LOG2N, $clog2(N), index width; derived, never overridden
- DW, 32, sample width; signed Q16.16 (bit 31 sign, 30:16 integer, 15:0 fraction)
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input sample present
- in_ready  out  1  buffer can accept a sample this cycle
- in_r  in  DW  real part, signed Q16.16
- in_i  in  DW  imaginary part, signed Q16.16
- in_last  in  1  producer marks final sample of a frame
- out_valid  out  1  output sample present
- out_ready  in  1  consumer accepts this cycle
- out_r  out  DW  real part, natural order
- out_i  out  DW  imaginary part, natural order
- out_idx  out  LOG2N  natural-order bin index of current output
- out_last  out  1  high with bin N-1
- frame_err  out  1  sticky: in_last seen with write count != N-1

## Operation
- Storage: 2 banks x N entries x 2·DW bits, flip-flop array; bank_full[1:0] flags.
- Write side: wbank, wcnt. in_ready = !bank_full[wbank]. On in_valid && in_ready: mem[wbank][bitrev(wcnt)] <= {in_r, in_i}; wcnt++. When wcnt == N-1 is accepted: bank_full[wbank] <= 1, wbank toggles, wcnt wraps to 0.
- bitrev reverses the LOG2N bits (N=16: 1→8, 3→12, 6→6).
- Read side: rbank, rcnt. out_valid = bank_full[rbank]; out_idx = rcnt; out_r/out_i = mem[rbank][rcnt] (after optional scaling); out_last = out_valid && rcnt == N-1. On out_valid && out_ready: rcnt++; at N-1: bank_full[rbank] <= 0, rbank toggles, rcnt wraps.
- When out_valid is low, out_r, out_i, out_idx, out_last drive 0.
- in_last: if accepted with wcnt != N-1, frame_err <= 1 (sticky until reset); framing still driven solely by wcnt. in_last with wcnt == N-1 is legal.
- Simultaneous release/fill of the same bank: full flags are registered; a bank freed at edge t is writable from cycle t+1.
- Both banks full: in_ready low; input stalls until the reader finishes a frame.
- Reset mid-frame: all partial data discarded; counters, banks and flags cleared.

## Timing
- Reset values: in_ready 1, out_valid 0, out_r/out_i/out_idx 0, out_last 0, frame_err 0, wbank=rbank=0, wcnt=rcnt=0.
- Latency: last sample of a frame accepted at edge t → out_valid high in cycle after t, bin 0 presented then.
- Throughput: one sample/cycle in and out with out_ready held high; no bubble between frames.
- Output data is combinational from registered storage; stable while out_valid && !out_ready.

## Configuration
- FFT_REORDER_SCALE_EN defined: out = (x + 2^(LOG2N-1)) >>> LOG2N, computed in DW+1 bits and truncated to DW (1/N normalisation, round half up, no overflow possible). N=16: 0x00100000 → 0x00010000.
- Undefined: stored samples pass through unchanged.

## Structure
- Package fft_pkg: FFT_N, FFT_LOG2N, FFT_DW, Q16.16 typedef for a complex sample {re, im}, bitrev function.
- Sub-module fft_reorder_bank: one N-entry bank with write port and combinational read port; instantiated twice.

## Test plan
- Single frame, in_r = bitrev(k)<<16 for k=0..15, out_ready=1 → out_r = k<<16 for bins 0..15, out_last at bin 15, out_valid first in cycle after sample 15.
- Three back-to-back frames, out_ready=1 → 48 outputs, no idle cycle, in_ready never low.
- out_ready held low for 40 cycles after reset with input streaming → in_ready drops after 32 accepted samples; releasing out_ready drains frames in order, no loss or duplication.
- in_last on 10th sample → frame_err=1 and stays 1; frame still closes after 16 samples.
- Reset asserted after 7 samples of a frame → out_valid 0, in_ready 1; next full frame outputs correctly from bin 0.
- With FFT_REORDER_SCALE_EN, input 0x00000008 and 0xFFFFFFF7 → outputs 0x00000001 and 0xFFFFFFFF.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants, Q16.16 complex sample types and the index bit-reversal helper
// used by the 16-point FFT output reorder buffer.
package fft_pkg;

   localparam int FFT_N     = 16;
   localparam int FFT_LOG2N = $clog2(FFT_N);
   localparam int FFT_DW    = 32;

   typedef logic signed [FFT_DW-1:0] q16_16_t;

   typedef struct packed {
      q16_16_t re;
      q16_16_t im;
   } cplx_t;

   // Reverses the low 'width' bits of x (width <= 8); upper bits return as zero.
   function automatic logic [7:0] bitrev(input logic [7:0] x, input int width);
      logic [7:0] r;
      r = '0;
      for (int b = 0; b < 8; b++) begin
         if (b < width) r[b] = x[3'(width - 1 - b)];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One N-entry flip-flop bank of the reorder buffer: a single write port and a
// combinational read port.
module fft_reorder_bank #(
   parameter int N = 16,
   parameter int W = 64,
   localparam int AW = $clog2(N)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [N];

   // Contents need no reset: validity is tracked by the owner's full flags.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fft_reorder.sv
// Ping-pong reorder buffer: bit-reversed FFT results in, natural-order frames out.
// Define FFT_REORDER_SCALE_EN to apply 1/N rounding normalisation on the output.
module fft_reorder
   import fft_pkg::*;
#(
   parameter int N  = FFT_N,
   parameter int DW = FFT_DW,
   localparam int LOG2N = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DW-1:0]    in_r,
   input  logic [DW-1:0]    in_i,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DW-1:0]    out_r,
   output logic [DW-1:0]    out_i,
   output logic [LOG2N-1:0] out_idx,
   output logic             out_last,
   output logic             frame_err
);

   localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

   logic [1:0]       bank_full;
   logic             wbank;
   logic             rbank;
   logic [LOG2N-1:0] wcnt;
   logic [LOG2N-1:0] rcnt;
   logic [LOG2N-1:0] waddr;
   logic [2*DW-1:0]  rdata [2];
   logic [2*DW-1:0]  rsel;
   logic [DW-1:0]    data_r;
   logic [DW-1:0]    data_i;
   logic             accept;
   logic             release_rd;

   assign in_ready   = !bank_full[wbank];
   assign accept     = in_valid && in_ready;
   assign out_valid  = bank_full[rbank];
   assign release_rd = out_valid && out_ready;
   assign waddr      = LOG2N'(bitrev(8'(wcnt), LOG2N));

   for (genvar b = 0; b < 2; b++) begin : g_bank
      fft_reorder_bank #(
         .N (N),
         .W (2 * DW)
      ) u_bank (
         .clk   (clk),
         .we    (accept && (wbank == 1'(b))),
         .waddr (waddr),
         .wdata ({in_r, in_i}),
         .raddr (rcnt),
         .rdata (rdata[b])
      );
   end

   assign rsel = rdata[rbank];

`ifdef FFT_REORDER_SCALE_EN
   // Round half up, then divide by N; the extra bit keeps the rounding add from overflowing.
   function automatic logic [DW-1:0] scale(input logic [DW-1:0] x);
      logic signed [DW:0] t;
      t = signed'({x[DW-1], x});
      t = t + signed'((DW + 1)'(1) << (LOG2N - 1));
      t = t >>> LOG2N;
      return t[DW-1:0];
   endfunction

   assign data_r = scale(rsel[2*DW-1:DW]);
   assign data_i = scale(rsel[DW-1:0]);
`else
   assign data_r = rsel[2*DW-1:DW];
   assign data_i = rsel[DW-1:0];
`endif

   // Output fields are forced to zero whenever no sample is being presented.
   always_comb begin
      out_r    = '0;
      out_i    = '0;
      out_idx  = '0;
      out_last = 1'b0;
      if (out_valid) begin
         out_r    = data_r;
         out_i    = data_i;
         out_idx  = rcnt;
         out_last = (rcnt == LAST);
      end
   end

   // Writer fills a bank and the reader drains the other, so the two flag
   // updates below never target the same bank in one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_full <= '0;
         wbank     <= 1'b0;
         rbank     <= 1'b0;
         wcnt      <= '0;
         rcnt      <= '0;
         frame_err <= 1'b0;
      end else begin
         if (accept) begin
            wcnt <= wcnt + LOG2N'(1);
            if (wcnt == LAST) begin
               bank_full[wbank] <= 1'b1;
               wbank            <= !wbank;
            end
            if (in_last && (wcnt != LAST)) frame_err <= 1'b1;
         end
         if (release_rd) begin
            rcnt <= rcnt + LOG2N'(1);
            if (rcnt == LAST) begin
               bank_full[rbank] <= 1'b0;
               rbank            <= !rbank;
            end
         end
      end
   end

endmodule

// File: tb/tb_fft_reorder.sv
// Self-checking bench for fft_reorder: a reference model pushes natural-order
// expectations to a scoreboard as each frame completes; a monitor pops and compares.
module tb_fft_reorder;
   import fft_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_r;
   logic [31:0] in_i;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_r;
   logic [31:0] out_i;
   logic [3:0]  out_idx;
   logic        out_last;
   logic        frame_err;

   typedef struct packed {
      logic [3:0]  idx;
      logic        last;
      logic [31:0] r;
      logic [31:0] i;
   } exp_t;

   exp_t        sb[$];
   logic [63:0] arr [16];
   int          mdl_cnt = 0;
   int          vectors = 0;
   int          miscompares = 0;
   int          stalls = 0;
   int          pops = 0;
   int          mark_pops = 0;
   int          cyc = 0;
   int          first_pop_cyc = 0;
   int          last_pop_cyc = 0;

   fft_reorder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_r      (in_r),
      .in_i      (in_i),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_r     (out_r),
      .out_i     (out_i),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [31:0] expect_val(input logic [31:0] x);
`ifdef FFT_REORDER_SCALE_EN
      logic signed [32:0] t;
      t = signed'({x[31], x}) + 33'sd8;
      t = t >>> 4;
      return t[31:0];
`else
      return x;
`endif
   endfunction

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Natural-order bin j holds the sample that arrived at position bitrev(j).
   task automatic model_accept(input logic [31:0] r, input logic [31:0] i);
      exp_t e;
      arr[mdl_cnt] = {r, i};
      if (mdl_cnt == 15) begin
         for (int j = 0; j < 16; j++) begin
            e.idx  = 4'(j);
            e.last = (j == 15);
            e.r    = expect_val(arr[bitrev(8'(j), 4)][63:32]);
            e.i    = expect_val(arr[bitrev(8'(j), 4)][31:0]);
            sb.push_back(e);
         end
         mdl_cnt = 0;
      end else begin
         mdl_cnt++;
      end
   endtask

   task automatic apply_stimulus(input logic [31:0] r, input logic [31:0] i,
                                 input logic last, output bit acc);
      @(negedge clk);
      in_valid = 1'b1;
      in_r     = r;
      in_i     = i;
      in_last  = last;
      acc      = in_ready;
      @(posedge clk);
      if (acc) model_accept(r, i);
   endtask

   task automatic send_sample(input logic [31:0] r, input logic [31:0] i, input logic last);
      bit acc;
      int n;
      n = 0;
      do begin
         apply_stimulus(r, i, last, acc);
         if (!acc) stalls++;
         n++;
      end while (!acc && n < 100);
      if (!acc) check_output("send_timeout", 64'(acc), 64'd1);
   endtask

   task automatic idle();
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_drain();
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (sb.size() == 0) break;
      end
      check_output("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (2) @(posedge clk);
      sb.delete();
      mdl_cnt = 0;
   endtask

   // Monitor: every handshake pops the scoreboard; idle outputs must read zero.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL unexpected_out: observed idx %0d with empty scoreboard", out_idx);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check_output("out_data", {out_r, out_i}, {e.r, e.i});
            check_output("out_idx", 64'(out_idx), 64'(e.idx));
            check_output("out_last", 64'(out_last), 64'(e.last));
         end
         if (pops == mark_pops) first_pop_cyc = cyc;
         pops++;
         last_pop_cyc = cyc;
      end else if (rst_n && !out_valid) begin
         check_output("idle_zero", {out_r, out_i}, 64'd0);
         check_output("idle_idx_last", {59'd0, out_idx, out_last}, 64'd0);
      end
   end

   initial begin
      int  k;
      int  base;
      bit  acc;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_r      = '0;
      in_i      = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;

      // Reset values
      repeat (2) @(negedge clk);
      check_output("rst_in_ready", 64'(in_ready), 64'd1);
      check_output("rst_out_valid", 64'(out_valid), 64'd0);
      check_output("rst_out_data", {out_r, out_i}, 64'd0);
      check_output("rst_out_idx", 64'(out_idx), 64'd0);
      check_output("rst_out_last", 64'(out_last), 64'd0);
      check_output("rst_frame_err", 64'(frame_err), 64'd0);
      rst_n = 1'b1;

      // Single frame: bit-reversed ramp should come out as a natural ramp
      $display("[TB] single frame");
      for (int j = 0; j < 16; j++)
         send_sample({12'd0, 4'(bitrev(8'(j), 4)), 16'd0}, 32'(j * 3), j == 15);
      idle();
      @(negedge clk);
      check_output("latency_valid", 64'(out_valid), 64'd1);
      check_output("latency_idx", 64'(out_idx), 64'd0);
      wait_drain();

      // Three back-to-back frames with the consumer always ready
      $display("[TB] three back-to-back frames");
      stalls    = 0;
      mark_pops = pops;
      for (int j = 0; j < 48; j++)
         send_sample($urandom, $urandom, (j % 16) == 15);
      idle();
      wait_drain();
      check_output("b2b_stalls", 64'(stalls), 64'd0);
      check_output("b2b_count", 64'(pops - mark_pops), 64'd48);
      check_output("b2b_span", 64'(last_pop_cyc - first_pop_cyc), 64'd47);

      // Backpressure: both banks fill, then drain in order
      $display("[TB] backpressure");
      do_reset();
      out_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      k = 0;
      for (int c = 0; c < 40; c++) begin
         apply_stimulus(32'h1000_0000 + 32'(k), ~32'(k), 1'b0, acc);
         if (acc) k++;
      end
      idle();
      @(negedge clk);
      check_output("bp_accepted", 64'(k), 64'd32);
      check_output("bp_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      base      = pops;
      out_ready = 1'b1;
      wait_drain();
      check_output("bp_drained", 64'(pops - base), 64'd32);

      // Early in_last flags an error but framing still follows the count
      $display("[TB] early in_last");
      check_output("ferr_before", 64'(frame_err), 64'd0);
      base = pops;
      for (int j = 0; j < 16; j++) begin
         send_sample(32'(j) << 20, 32'hABCD_0000 | 32'(j), j == 9);
         if (j == 9) begin
            #1;
            check_output("ferr_set", 64'(frame_err), 64'd1);
         end
      end
      idle();
      wait_drain();
      check_output("ferr_sticky", 64'(frame_err), 64'd1);
      check_output("ferr_frame_out", 64'(pops - base), 64'd16);

      // Reset partway through a frame discards it
      $display("[TB] reset mid-frame");
      for (int j = 0; j < 7; j++) send_sample($urandom, $urandom, 1'b0);
      idle();
      do_reset();
      @(negedge clk);
      check_output("mrst_out_valid", 64'(out_valid), 64'd0);
      check_output("mrst_in_ready", 64'(in_ready), 64'd1);
      check_output("mrst_frame_err", 64'(frame_err), 64'd0);
      rst_n = 1'b1;
      base  = pops;
      for (int j = 0; j < 16; j++) send_sample(32'(j * 7), 32'(100 - j), j == 15);
      idle();
      wait_drain();
      check_output("mrst_frame_out", 64'(pops - base), 64'd16);

      // Small and negative values that exercise the rounding of the scaled build
      $display("[TB] rounding values");
      base = pops;
      for (int j = 0; j < 16; j++) begin
         case (j)
            0:       send_sample(32'h0000_0008, 32'hFFFF_FFF7, 1'b0);
            1:       send_sample(32'hFFFF_FFF7, 32'h0010_0000, 1'b0);
            default: send_sample($urandom, $urandom, j == 15);
         endcase
      end
      idle();
      wait_drain();
      check_output("round_frame_out", 64'(pops - base), 64'd16);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
